// File: rtl/ram8_arbiter.sv
// ram8_arbiter: two-requester arbiter/sequencer for one shared 8-word RAM bank.
// Each grant runs IDLE -> ACCESS -> RESP, one RAM access per transaction.
// Tie-break is round-robin on the last winner by default. Define
// RAM8_ARB_FIXED_PRIORITY_EN to make requester 0 always win ties.
module ram8_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_load,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   owner;   // 0 = requester 0, 1 = requester 1
  logic   winner;
  logic   any_req;

`ifndef RAM8_ARB_FIXED_PRIORITY_EN
  logic   last;    // most recent winner; the other side wins the next tie
`endif

  // Pick the requester to grant from the current request lines.
  always_comb begin
    any_req = req0 | req1;
    winner  = 1'b0;
`ifdef RAM8_ARB_FIXED_PRIORITY_EN
    if (req0) begin
      winner = 1'b0;
    end else begin
      winner = 1'b1;
    end
`else
    if (req0 && req1) begin
      winner = ~last;
    end else if (req0) begin
      winner = 1'b0;
    end else begin
      winner = 1'b1;
    end
`endif
  end

  // Transaction sequencer: latch the winning request, drive one RAM cycle, pulse ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
`ifndef RAM8_ARB_FIXED_PRIORITY_EN
      last     <= 1'b1;
`endif
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      mem_load <= 1'b0;
      mem_addr <= {ADDR_WIDTH{1'b0}};
      mem_in   <= {DATA_WIDTH{1'b0}};
      rdata0   <= {DATA_WIDTH{1'b0}};
      rdata1   <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (any_req) begin
            state <= ACCESS;
            owner <= winner;
`ifndef RAM8_ARB_FIXED_PRIORITY_EN
            last  <= winner;
`endif
            gnt0  <= ~winner;
            gnt1  <= winner;
            if (winner) begin
              mem_addr <= addr1;
              mem_in   <= wdata1;
              mem_load <= we1;
            end else begin
              mem_addr <= addr0;
              mem_in   <= wdata0;
              mem_load <= we0;
            end
          end
        end
        ACCESS: begin
          // mem_load doubles as the latched write flag; a read captures mem_out here.
          mem_load <= 1'b0;
          if (!mem_load) begin
            if (owner) begin
              rdata1 <= mem_out;
            end else begin
              rdata0 <= mem_out;
            end
          end
          ack0  <= ~owner;
          ack1  <= owner;
          state <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          mem_load <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed testbench for ram8_arbiter with a behavioural 8x16 RAM bank.
module tb_ram8_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [2:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, gnt0, gnt1, mem_load;
  logic [15:0] rdata0, rdata1, mem_in, mem_out;
  logic [2:0]  mem_addr;
  logic [15:0] ram [8];
  logic        exp_g1;

  int checks = 0;
  int errors = 0;

  ram8_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // RAM bank of load-enabled registers, no reset.
  always_ff @(posedge clk) begin
    if (mem_load) ram[mem_addr] <= mem_in;
  end
  assign mem_out = ram[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 16'h0000;
`ifdef RAM8_ARB_FIXED_PRIORITY_EN
    exp_g1 = 1'b0;
`else
    exp_g1 = 1'b1;
`endif
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 3'd0; addr1 = 3'd0; wdata0 = 16'h0000; wdata1 = 16'h0000;
    tick(); tick();
    check("rst_acks",  {30'd0, ack0, ack1}, 32'd0);
    check("rst_gnts",  {30'd0, gnt0, gnt1}, 32'd0);
    check("rst_load",  {31'd0, mem_load}, 32'd0);
    check("rst_maddr", {29'd0, mem_addr}, 32'd0);
    check("rst_min",   {16'd0, mem_in}, 32'd0);
    check("rst_rdata", {rdata0, rdata1}, 32'd0);
    reset = 1'b0;

    // req0 writes 16'h00FF to addr 3
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 16'h00FF;
    tick();
    check("w_access_gnt",  {30'd0, gnt0, gnt1}, 32'd2);
    check("w_access_load", {31'd0, mem_load}, 32'd1);
    check("w_access_addr", {29'd0, mem_addr}, 32'd3);
    check("w_access_in",   {16'd0, mem_in}, 32'h00FF);
    check("w_access_ack",  {31'd0, ack0}, 32'd0);
    req0 = 1'b0;
    tick();
    check("w_resp_ack",   {30'd0, ack0, ack1}, 32'd2);
    check("w_resp_load",  {31'd0, mem_load}, 32'd0);
    check("w_resp_rdata", {16'd0, rdata0}, 32'd0);
    tick();
    check("w_idle", {28'd0, ack0, ack1, gnt0, gnt1}, 32'd0);

    // req1 reads addr 3
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd3;
    tick();
    check("r1_gnt",  {30'd0, gnt0, gnt1}, 32'd1);
    check("r1_load", {31'd0, mem_load}, 32'd0);
    req1 = 1'b0;
    tick();
    check("r1_ack",   {30'd0, ack0, ack1}, 32'd1);
    check("r1_rdata", {16'd0, rdata1}, 32'h00FF);
    tick();

    // req1 writes 16'h1234 to addr 6
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd6; wdata1 = 16'h1234;
    tick(); req1 = 1'b0;
    tick(); tick();
    check("w6_ram", {16'd0, ram[6]}, 32'h1234);

    // tie, both continuous reads: req0 addr 6, req1 addr 3
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd6;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd3; wdata1 = 16'h0000;
    tick();
    check("tie1_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    tick();
    check("tie1_ack",   {30'd0, ack0, ack1}, 32'd2);
    check("tie1_rdata", {16'd0, rdata0}, 32'h1234);
    tick();
    tick();
    check("tie2_gnt", {30'd0, gnt0, gnt1}, {30'd0, ~exp_g1, exp_g1});
    tick();
    check("tie2_ack", {30'd0, ack0, ack1}, {30'd0, ~exp_g1, exp_g1});
    tick(); tick();
    check("tie3_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    tick();
    check("tie3_ack", {30'd0, ack0, ack1}, 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    check("tie_end", {28'd0, ack0, ack1, gnt0, gnt1}, 32'd0);

    // req0 writes 16'h7777 to addr 7
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd7; wdata0 = 16'h7777;
    tick(); req0 = 1'b0; we0 = 1'b0;
    tick(); tick();

    // req1 reads addr 7; its inputs change during ACCESS
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd7; wdata1 = 16'hDEAD;
    tick();
    check("ign_addr", {29'd0, mem_addr}, 32'd7);
    addr1 = 3'd2; we1 = 1'b1; wdata1 = 16'hBEEF;
    tick();
    check("ign_load",  {31'd0, mem_load}, 32'd0);
    check("ign_addr2", {29'd0, mem_addr}, 32'd7);
    check("ign_rdata", {16'd0, rdata1}, 32'h7777);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    check("ign_ram2", {16'd0, ram[2]}, 32'h0000);

    // reset during ACCESS of a read: discarded, no ack
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd7;
    tick();
    req0 = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_ack",   {30'd0, ack0, ack1}, 32'd0);
    check("rr_rdata", {rdata0, rdata1}, 32'd0);
    check("rr_gnt",   {30'd0, gnt0, gnt1}, 32'd0);
    tick();
    check("rr_noack", {30'd0, ack0, ack1}, 32'd0);

    // reset during ACCESS of write 16'hABCD to addr 5: still commits
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; wdata0 = 16'hABCD;
    tick();
    check("rw_load", {31'd0, mem_load}, 32'd1);
    req0 = 1'b0; we0 = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_ack",   {30'd0, ack0, ack1}, 32'd0);
    check("rw_out",   {15'd0, mem_load, mem_in}, 32'd0);
    tick();
    check("rw_noack", {30'd0, ack0, ack1}, 32'd0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd5;
    tick(); req1 = 1'b0;
    tick();
    check("rw_read_ack", {30'd0, ack0, ack1}, 32'd1);
    check("rw_read",     {16'd0, rdata1}, 32'hABCD);
    tick();

    // req0 held high after ack: back-to-back reads every 3 cycles
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd5;
    tick(); tick();
    check("b2b_ack1",  {30'd0, ack0, ack1}, 32'd2);
    check("b2b_rdata", {16'd0, rdata0}, 32'hABCD);
    tick();
    check("b2b_gap", {28'd0, ack0, ack1, gnt0, gnt1}, 32'd0);
    tick();
    check("b2b_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    tick();
    check("b2b_ack2", {30'd0, ack0, ack1}, 32'd2);
    req0 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
